hazard_ctrl: RTL and testbench

Parametrised hazard and pipeline-control unit for the five-stage RISC-V core (fetch/decode/execute/memory/writeback). It supplies EX-stage operand forwarding selects, load-use stalls, branch flushes, a stall for multi-cycle data-memory handshakes with a timeout, and a halt sequence on `finishW`. Free-running performance counters are exposed to the negedge trace logic in the core top. Instantiated once in the core top; all stage modules take its stall/flush outputs.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/fwd_sel.sv | 30 +++
 rtl/hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states, forwarding-select encodings
// and default widths matching the core's consts.v.
package pipe_pkg;

    localparam int REG_SIZE_DEF = 5;
    localparam int WORD_DEF     = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// EX-stage operand forwarding select for one source register.
// The memory-stage result is newer than writeback, so it wins; x0 is never forwarded.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_SIZE = REG_SIZE_DEF
) (
    input  logic [REG_SIZE-1:0] rs,
    input  logic [REG_SIZE-1:0] write_reg_m,
    input  logic                reg_write_m,
    input  logic [REG_SIZE-1:0] write_reg_w,
    input  logic                reg_write_w,
    output logic [1:0]          fwd
);

    logic hit_m;
    logic hit_w;

    always_comb begin
        hit_m = reg_write_m && (write_reg_m != '0) && (write_reg_m == rs);
        hit_w = reg_write_w && (write_reg_w != '0) && (write_reg_w == rs);
        fwd   = FWD_RF;
        if (hit_m) begin
            fwd = FWD_M;
        end else if (hit_w) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit: forwarding, load-use stall, branch flush,
// data-memory wait with timeout, halt on finish, saturating performance counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_SIZE = REG_SIZE_DEF,
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] rs1D,
    input  logic [REG_SIZE-1:0] rs2D,
    input  logic [REG_SIZE-1:0] rs1E,
    input  logic [REG_SIZE-1:0] rs2E,
    input  logic [REG_SIZE-1:0] writeRegE,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic [REG_SIZE-1:0] writeRegW,
    input  logic                regWriteE,
    input  logic                regWriteM,
    input  logic                regWriteW,
    input  logic                mem2regE,
    input  logic                PCSrcM,
    input  logic                memReqM,
    input  logic                memReadyM,
    input  logic                finishW,
    output logic [1:0]          fwdAE,
    output logic [1:0]          fwdBE,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                stallM,
    output logic                flushD,
    output logic                flushE,
    output logic                flushW,
    output logic                halted,
    output logic                memErr,
    output logic [CNT_W-1:0]    cycleCnt,
    output logic [CNT_W-1:0]    stallCnt,
    output logic [CNT_W-1:0]    flushCnt,
    output hz_state_e           dbg_state
);

    localparam int                WAIT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    hz_state_e         state_q, state_d, cur_state;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic              halted_q, halted_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_wait;
    logic              lw_stall;

    fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd_a (
        .rs          (rs1E),
        .write_reg_m (writeRegM),
        .reg_write_m (regWriteM),
        .write_reg_w (writeRegW),
        .reg_write_w (regWriteW),
        .fwd         (fwdAE)
    );

    fwd_sel #(.REG_SIZE(REG_SIZE)) u_fwd_b (
        .rs          (rs2E),
        .write_reg_m (writeRegM),
        .reg_write_m (regWriteM),
        .write_reg_w (writeRegW),
        .reg_write_w (regWriteW),
        .fwd         (fwdBE)
    );

    // While reset is held the control outputs behave as in RUN, whatever the stored state.
    always_comb begin
        cur_state = reset ? RUN : state_q;
        mem_wait  = memReqM && !memReadyM;
        lw_stall  = mem2regE && regWriteE && (writeRegE != '0) &&
                    ((writeRegE == rs1D) || (writeRegE == rs2D));
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;
        if (cur_state == HALT) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (mem_wait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (PCSrcM) begin
            // A taken branch discards the younger load-use pair, so fetch must not stall.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lw_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        wait_inc   = wait_cnt_q + 1'b1;
        unique case (state_q)
            RUN: begin
                if (finishW) begin
                    state_d = HALT;
                end else if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (finishW) begin
                    state_d = HALT;
                end else if (memReqM && memReadyM) begin
                    state_d = RUN;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_d   = HALT;
                        mem_err_d = 1'b1;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        halted_d = (state_d == HALT);
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != HALT) begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
            if (stallF && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flushD && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            mem_err_q   <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            mem_err_q   <= mem_err_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign memErr    = mem_err_q;
    assign cycleCnt  = cycle_cnt_q;
    assign stallCnt  = stall_cnt_q;
    assign flushCnt  = flush_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    localparam int REG_SIZE = 5;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                clk;
    logic                reset;
    logic [REG_SIZE-1:0] rs1D, rs2D, rs1E, rs2E;
    logic [REG_SIZE-1:0] writeRegE, writeRegM, writeRegW;
    logic                regWriteE, regWriteM, regWriteW;
    logic                mem2regE, PCSrcM, memReqM, memReadyM, finishW;
    logic [1:0]          fwdAE, fwdBE;
    logic                stallF, stallD, stallE, stallM;
    logic                flushD, flushE, flushW;
    logic                halted, memErr;
    logic [CNT_W-1:0]    cycleCnt, stallCnt, flushCnt;
    hz_state_e           dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state (plain integers / flags)
    int m_halt, m_wait, m_wcnt, m_err, m_cyc, m_stl, m_fls;
    int halt_run;
    // expected combinational outputs for the current cycle
    logic [1:0] e_fwd_a, e_fwd_b;
    logic       e_stall_f, e_stall_d, e_stall_e, e_stall_m;
    logic       e_flush_d, e_flush_e, e_flush_w;

    hazard_ctrl #(
        .REG_SIZE (REG_SIZE),
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rs1E      (rs1E),
        .rs2E      (rs2E),
        .writeRegE (writeRegE),
        .writeRegM (writeRegM),
        .writeRegW (writeRegW),
        .regWriteE (regWriteE),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .mem2regE  (mem2regE),
        .PCSrcM    (PCSrcM),
        .memReqM   (memReqM),
        .memReadyM (memReadyM),
        .finishW   (finishW),
        .fwdAE     (fwdAE),
        .fwdBE     (fwdBE),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .stallM    (stallM),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushW    (flushW),
        .halted    (halted),
        .memErr    (memErr),
        .cycleCnt  (cycleCnt),
        .stallCnt  (stallCnt),
        .flushCnt  (flushCnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    function automatic logic [1:0] ref_fwd(input logic [REG_SIZE-1:0] rs);
        if (regWriteM && writeRegM != 0 && writeRegM == rs) return 2'd2;
        if (regWriteW && writeRegW != 0 && writeRegW == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic ref_comb();
        bit halt_now, waiting_now, load_use;
        halt_now    = (m_halt != 0) && !reset;
        waiting_now = memReqM && !memReadyM;
        load_use    = mem2regE && regWriteE && writeRegE != 0 &&
                      (writeRegE == rs1D || writeRegE == rs2D);
        e_fwd_a = ref_fwd(rs1E);
        e_fwd_b = ref_fwd(rs2E);
        {e_stall_f, e_stall_d, e_stall_e, e_stall_m} = 4'b0000;
        {e_flush_d, e_flush_e, e_flush_w}            = 3'b000;
        if (halt_now) begin
            {e_stall_f, e_stall_d, e_stall_e, e_stall_m} = 4'b1111;
        end else if (waiting_now) begin
            {e_stall_f, e_stall_d, e_stall_e, e_stall_m} = 4'b1111;
            e_flush_w = 1'b1;
        end else if (PCSrcM) begin
            {e_flush_d, e_flush_e} = 2'b11;
        end else if (load_use) begin
            {e_stall_f, e_stall_d, e_flush_e} = 3'b111;
        end
    endtask

    task automatic ref_clock();
        if (reset) begin
            m_halt = 0; m_wait = 0; m_wcnt = 0; m_err = 0;
            m_cyc = 0; m_stl = 0; m_fls = 0;
            return;
        end
        if (m_halt != 0) return;
        m_cyc = sat_inc(m_cyc);
        if (e_stall_f) m_stl = sat_inc(m_stl);
        if (e_flush_d) m_fls = sat_inc(m_fls);
        if (finishW) begin
            m_halt = 1; m_wait = 0;
        end else if (m_wait == 0) begin
            if (memReqM && !memReadyM) begin
                m_wait = 1; m_wcnt = 0;
            end
        end else if (memReqM && memReadyM) begin
            m_wait = 0;
        end else begin
            m_wcnt++;
            if (m_wcnt >= WAIT_MAX) begin
                m_halt = 1; m_err = 1; m_wait = 0;
            end
        end
    endtask

    function automatic hz_state_e ref_state();
        if (m_halt != 0) return HALT;
        if (m_wait != 0) return MEM_WAIT;
        return RUN;
    endfunction

    // driver tasks
    task automatic idle_inputs();
        reset = 1'b0;
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        writeRegE = '0; writeRegM = '0; writeRegW = '0;
        regWriteE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        mem2regE = 1'b0; PCSrcM = 1'b0; memReqM = 1'b0; memReadyM = 1'b0; finishW = 1'b0;
    endtask

    task automatic rand_inputs();
        rs1D      = REG_SIZE'($urandom_range(0, 7));
        rs2D      = REG_SIZE'($urandom_range(0, 7));
        rs1E      = REG_SIZE'($urandom_range(0, 7));
        rs2E      = REG_SIZE'($urandom_range(0, 7));
        writeRegE = REG_SIZE'($urandom_range(0, 7));
        writeRegM = REG_SIZE'($urandom_range(0, 7));
        writeRegW = REG_SIZE'($urandom_range(0, 7));
        regWriteE = ($urandom_range(0, 3) != 0);
        regWriteM = ($urandom_range(0, 3) != 0);
        regWriteW = ($urandom_range(0, 3) != 0);
        mem2regE  = ($urandom_range(0, 2) == 0);
        PCSrcM    = ($urandom_range(0, 4) == 0);
        memReqM   = (m_wait != 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        memReadyM = ($urandom_range(0, 2) == 0);
        finishW   = ($urandom_range(0, 59) == 0);
        reset     = (halt_run > 3) || ($urandom_range(0, 24) == 0);
    endtask

    // called at a negedge with inputs driven; checks, then advances one clock
    task automatic step();
        #1;
        ref_comb();
        check_eq("fwdAE",    32'(fwdAE),    32'(e_fwd_a));
        check_eq("fwdBE",    32'(fwdBE),    32'(e_fwd_b));
        check_eq("stallF",   32'(stallF),   32'(e_stall_f));
        check_eq("stallD",   32'(stallD),   32'(e_stall_d));
        check_eq("stallE",   32'(stallE),   32'(e_stall_e));
        check_eq("stallM",   32'(stallM),   32'(e_stall_m));
        check_eq("flushD",   32'(flushD),   32'(e_flush_d));
        check_eq("flushE",   32'(flushE),   32'(e_flush_e));
        check_eq("flushW",   32'(flushW),   32'(e_flush_w));
        check_eq("halted",   32'(halted),   32'(m_halt));
        check_eq("memErr",   32'(memErr),   32'(m_err));
        check_eq("cycleCnt", 32'(cycleCnt), 32'(m_cyc));
        check_eq("stallCnt", 32'(stallCnt), 32'(m_stl));
        check_eq("flushCnt", 32'(flushCnt), 32'(m_fls));
        check_eq("state",    32'(dbg_state), 32'(ref_state()));
        @(posedge clk);
        ref_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // scoreboard-driven stimulus
    initial begin
        idle_inputs();
        reset = 1'b1;
        m_halt = 0; m_wait = 0; m_wcnt = 0; m_err = 0;
        m_cyc = 0; m_stl = 0; m_fls = 0; halt_run = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_halted",   32'(halted),    32'd0);
        check_eq("rst_memErr",   32'(memErr),    32'd0);
        check_eq("rst_cycleCnt", 32'(cycleCnt),  32'd0);
        check_eq("rst_state",    32'(dbg_state), 32'(RUN));
        step();

        // forwarding priority and x0
        rs1E = 5; writeRegM = 5; regWriteM = 1; writeRegW = 5; regWriteW = 1;
        #1 check_eq("tp_fwd_m", 32'(fwdAE), 32'd2);
        step();
        rs1E = 0; writeRegM = 0; writeRegW = 0;
        #1 check_eq("tp_fwd_x0", 32'(fwdAE), 32'd0);
        step();
        rs1E = 5; writeRegM = 5; writeRegW = 5; regWriteM = 0;
        #1 check_eq("tp_fwd_w", 32'(fwdAE), 32'd1);
        step();

        // load-use
        idle_inputs();
        mem2regE = 1; regWriteE = 1; writeRegE = 3; rs2D = 3;
        #1 check_eq("tp_lw_stallF", 32'(stallF), 32'd1);
        check_eq("tp_lw_flushE", 32'(flushE), 32'd1);
        step();
        idle_inputs();
        #1 check_eq("tp_lw_stallCnt", 32'(stallCnt), 32'd1);
        step();

        // load-use overridden by branch
        mem2regE = 1; regWriteE = 1; writeRegE = 3; rs2D = 3; PCSrcM = 1;
        #1 check_eq("tp_br_stallF", 32'(stallF), 32'd0);
        check_eq("tp_br_flushD", 32'(flushD), 32'd1);
        step();
        idle_inputs();
        #1 check_eq("tp_br_flushCnt", 32'(flushCnt), 32'd1);
        step();

        // 3-cycle memory wait
        memReqM = 1; memReadyM = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("tp_wait_stallM", 32'(stallM), 32'd1);
            step();
        end
        memReadyM = 1;
        step();
        idle_inputs();
        #1 check_eq("tp_wait_state", 32'(dbg_state), 32'(RUN));
        check_eq("tp_wait_memErr", 32'(memErr), 32'd0);
        step();

        // finish halts and freezes counters
        do_reset();
        repeat (5) step();
        finishW = 1;
        step();
        idle_inputs();
        #1 check_eq("tp_fin_halted", 32'(halted), 32'd1);
        repeat (5) step();
        #1 check_eq("tp_fin_cycleCnt", 32'(cycleCnt), 32'd6);

        // counter saturation
        do_reset();
        repeat (20) step();
        #1 check_eq("tp_sat_cycleCnt", 32'(cycleCnt), 32'(CNT_MAX));

        // memory timeout
        do_reset();
        memReqM = 1; memReadyM = 0;
        repeat (4) step();
        #1 check_eq("tp_to_early_memErr", 32'(memErr), 32'd0);
        step();
        idle_inputs();
        #1 check_eq("tp_to_memErr", 32'(memErr), 32'd1);
        check_eq("tp_to_halted", 32'(halted), 32'd1);
        check_eq("tp_to_stallF", 32'(stallF), 32'd1);
        repeat (3) step();
        #1 check_eq("tp_to_cycleCnt", 32'(cycleCnt), 32'd5);
        do_reset();
        #1 check_eq("tp_to_clr_memErr", 32'(memErr), 32'd0);
        check_eq("tp_to_clr_halted", 32'(halted), 32'd0);
        check_eq("tp_to_clr_cycleCnt", 32'(cycleCnt), 32'd0);
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
            halt_run = (m_halt != 0) ? halt_run + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
